conv_ctrl_p: RTL and testbench

CONV_CTRL_P -- requirements
Module: conv_ctrl_p

---
 rtl/conv_ctrl_pkg.sv | 24 ++
 rtl/conv_ctrl_p_wr_timeout_ctr.sv | 21 ++
 rtl/conv_ctrl_p.sv | 157 +++++++++++++++
 tb/tb_conv_ctrl_p.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared state encodings, write-status codes and limits for the conv controller
package conv_ctrl_pkg;
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ARM        = 4'd1,
        WAIT_DATA  = 4'd2,
        FIND_SP    = 4'd3,
        FILL       = 4'd4,
        RUN        = 4'd5,
        WRITE_REQ  = 4'd6,
        WAIT_WRITE = 4'd7,
        NEXT_IF    = 4'd8,
        UPDATE_SP  = 4'd9,
        STALL      = 4'd10,
        ERROR      = 4'd11
    } state_t;
    localparam logic [1:0] WR_BUSY   = 2'b00;
    localparam logic [1:0] WR_ACCEPT = 2'b10;
    localparam logic [1:0] WR_STALL  = 2'b11;
    localparam int PIPE_DEPTH_MIN = 2;
    localparam int PIPE_DEPTH_MAX = 8;
    localparam int FILL_W = 3;
    localparam int TMO_W  = 16;
endpackage

// File: rtl/conv_ctrl_p_wr_timeout_ctr.sv
// wr_timeout_ctr: saturating wait counter flagging when the write-status wait has run out
module wr_timeout_ctr
    import conv_ctrl_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [TMO_W-1:0] cnt;
    // count busy cycles, holding at all-ones so the count never wraps back to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign tc = cnt >= TMO_W'(LIMIT - 1);
endmodule

// File: rtl/conv_ctrl_p.sv
// conv_ctrl_p: convolution datapath sequencer (fill, run, write-back, IFMAP change, error handling)
module conv_ctrl_p
    import conv_ctrl_pkg::*;
#(
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int PIPE_DEPTH        = 3,
    parameter int WR_TIMEOUT        = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         if_empty,
    input  logic                         rd_empty,
    input  logic                         filter_cannot_read,
    input  logic [FILTER_ADDR_WIDTH-1:0] filter_waddr,
    input  logic                         sp_valid,
    input  logic                         f_co,
    input  logic                         go_next_stride,
    input  logic                         go_next_filter,
    input  logic                         stride_ended,
    input  logic                         is_last_filter,
    input  logic [1:0]                   wr_stat,
    input  logic                         ext_error,
    output logic                         chip_en,
    output logic                         global_rst,
    output logic                         en_p_traverse,
    output logic [PIPE_DEPTH-1:0]        pipe_en,
    output logic                         en_f_counter,
    output logic                         rst_f_counter,
    output logic                         next_stride,
    output logic                         next_filter,
    output logic                         rst_stride,
    output logic                         next_start,
    output logic                         rst_if_ctx,
    output logic                         done,
    output logic                         rst_result,
    output logic                         stall_signal,
    output logic                         timeout_err,
    output logic                         busy,
    output logic [3:0]                   state
);
    if (PIPE_DEPTH < PIPE_DEPTH_MIN || PIPE_DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
        $error("conv_ctrl_p: PIPE_DEPTH out of range");
    end

    state_t            st, nxt;
    logic [FILL_W-1:0] fill_cnt, fill_nxt;
    logic              freeze, run, wr_wait, tmo_tc, to_tmo, leave_err;

    assign freeze  = rd_empty | filter_cannot_read | !sp_valid | (is_last_filter & go_next_filter);
    assign run     = !freeze & !f_co;
    assign wr_wait = st == WAIT_WRITE && wr_stat != WR_ACCEPT && wr_stat != WR_STALL;
    assign state   = st;

    wr_timeout_ctr #(.LIMIT(WR_TIMEOUT)) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (st != WAIT_WRITE),
        .en      (wr_wait),
        .tc      (tmo_tc)
    );

    // state, fill progress and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= IDLE;
            fill_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            st          <= nxt;
            fill_cnt    <= fill_nxt;
            timeout_err <= leave_err ? 1'b0 : (to_tmo ? 1'b1 : timeout_err);
        end
    end

    // next-state and Moore/Mealy outputs; ext_error overrides every transition outside IDLE
    always_comb begin
        nxt           = st;
        fill_nxt      = '0;
        to_tmo        = 1'b0;
        leave_err     = 1'b0;
        chip_en       = st != IDLE;
        busy          = st != IDLE;
        global_rst    = 1'b0;
        en_p_traverse = 1'b0;
        pipe_en       = '0;
        en_f_counter  = 1'b0;
        rst_f_counter = 1'b0;
        next_stride   = 1'b0;
        next_filter   = 1'b0;
        rst_stride    = 1'b0;
        next_start    = 1'b0;
        rst_if_ctx    = 1'b0;
        done          = 1'b0;
        rst_result    = 1'b0;
        stall_signal  = 1'b0;
        case (st)
            IDLE:      nxt = start ? ARM : IDLE;
            ARM: begin
                global_rst = 1'b1;
                nxt        = start ? ARM : WAIT_DATA;
            end
            WAIT_DATA: nxt = (!if_empty && filter_waddr != '0) ? FIND_SP : WAIT_DATA;
            FIND_SP: begin
                en_p_traverse = !sp_valid;
                nxt           = sp_valid ? FILL : FIND_SP;
            end
            FILL: begin
                for (int k = 0; k < PIPE_DEPTH; k++) pipe_en[k] = !freeze && (FILL_W'(k) <= fill_cnt);
                fill_nxt = freeze ? fill_cnt : fill_cnt + 1'b1;
                nxt      = (!freeze && fill_cnt == FILL_W'(PIPE_DEPTH - 2)) ? RUN : FILL;
            end
            RUN: begin
                pipe_en      = {PIPE_DEPTH{run}};
                en_f_counter = run;
                next_stride  = run & !stride_ended & go_next_stride;
                next_filter  = !freeze & go_next_filter;
                rst_stride   = !freeze & go_next_filter;
                nxt          = (is_last_filter && go_next_filter) ? NEXT_IF :
                               freeze ? RUN : (f_co ? WRITE_REQ : RUN);
            end
            WRITE_REQ: begin
                done          = 1'b1;
                rst_f_counter = 1'b1;
                nxt           = WAIT_WRITE;
            end
            WAIT_WRITE: begin
                rst_result = wr_stat == WR_ACCEPT;
                to_tmo     = wr_wait && tmo_tc;
                nxt        = wr_stat == WR_ACCEPT ? RUN :
                             wr_stat == WR_STALL  ? STALL :
                             tmo_tc ? ERROR : WAIT_WRITE;
            end
            STALL: begin
                stall_signal = 1'b1;
                rst_result   = wr_stat == WR_ACCEPT;
                nxt          = wr_stat == WR_ACCEPT ? RUN : STALL;
            end
            NEXT_IF: begin
                rst_if_ctx = 1'b1;
                rst_stride = 1'b1;
                nxt        = UPDATE_SP;
            end
            UPDATE_SP: begin
                next_start = 1'b1;
                nxt        = FILL;
            end
            ERROR: begin
                stall_signal = 1'b1;
                nxt          = start ? IDLE : ERROR;
            end
            default:   nxt = IDLE;
        endcase
        if (ext_error && st != IDLE) nxt = ERROR;
        leave_err = st == ERROR && nxt == IDLE;
    end
endmodule

// File: tb/tb_conv_ctrl_p.sv
// tb_conv_ctrl_p: directed self-checking bench for conv_ctrl_p
module tb_conv_ctrl_p;
    logic       clk = 1'b0;
    logic       reset_n, start, if_empty, rd_empty, filter_cannot_read, sp_valid, f_co;
    logic       go_next_stride, go_next_filter, stride_ended, is_last_filter, ext_error;
    logic [7:0] filter_waddr;
    logic [1:0] wr_stat;
    logic       chip_en, global_rst, en_p_traverse, en_f_counter, rst_f_counter;
    logic       next_stride, next_filter, rst_stride, next_start, rst_if_ctx;
    logic       done, rst_result, stall_signal, timeout_err, busy;
    logic [2:0] pipe_en;
    logic [3:0] state;
    int         n_tests = 0;
    int         n_fail  = 0;

    conv_ctrl_p #(.FILTER_ADDR_WIDTH(8), .PIPE_DEPTH(3), .WR_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .if_empty(if_empty), .rd_empty(rd_empty),
        .filter_cannot_read(filter_cannot_read), .filter_waddr(filter_waddr), .sp_valid(sp_valid),
        .f_co(f_co), .go_next_stride(go_next_stride), .go_next_filter(go_next_filter),
        .stride_ended(stride_ended), .is_last_filter(is_last_filter), .wr_stat(wr_stat),
        .ext_error(ext_error), .chip_en(chip_en), .global_rst(global_rst),
        .en_p_traverse(en_p_traverse), .pipe_en(pipe_en), .en_f_counter(en_f_counter),
        .rst_f_counter(rst_f_counter), .next_stride(next_stride), .next_filter(next_filter),
        .rst_stride(rst_stride), .next_start(next_start), .rst_if_ctx(rst_if_ctx), .done(done),
        .rst_result(rst_result), .stall_signal(stall_signal), .timeout_err(timeout_err),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic go_to_run();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        step();
        chk("reach_run", state, 5);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; if_empty = 1'b1; rd_empty = 1'b0; filter_cannot_read = 1'b0;
        filter_waddr = 8'd0; sp_valid = 1'b0; f_co = 1'b0; go_next_stride = 1'b0;
        go_next_filter = 1'b0; stride_ended = 1'b0; is_last_filter = 1'b0; wr_stat = 2'b00;
        ext_error = 1'b0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_busy", {chip_en, busy, pipe_en}, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("post_rst_state", state, 0);
        chk("post_rst_out", {chip_en, busy, timeout_err}, 0);
        start = 1'b1;
        step();
        chk("arm_state", state, 1);
        chk("arm_out", {global_rst, chip_en, busy}, 3'b111);
        step();
        chk("arm_hold", state, 1);
        start = 1'b0;
        step();
        chk("wait_data", state, 2);
        step();
        chk("wait_data_hold", state, 2);
        if_empty = 1'b0;
        filter_waddr = 8'd5;
        step();
        chk("find_sp", state, 3);
        chk("p_traverse_on", en_p_traverse, 1);
        sp_valid = 1'b1;
        #1;
        chk("p_traverse_off", en_p_traverse, 0);
        step();
        chk("fill_state", state, 4);
        chk("fill_pipe0", pipe_en, 3'b001);
        step();
        chk("fill_pipe1", pipe_en, 3'b011);
        step();
        chk("run_state", state, 5);
        chk("run_pipe", pipe_en, 3'b111);
        chk("run_fcnt", en_f_counter, 1);
        go_next_stride = 1'b1;
        #1;
        chk("next_stride", next_stride, 1);
        stride_ended = 1'b1;
        #1;
        chk("stride_ended_blk", next_stride, 0);
        go_next_stride = 1'b0;
        stride_ended = 1'b0;
        go_next_filter = 1'b1;
        #1;
        chk("next_filter", {next_filter, rst_stride}, 2'b11);
        go_next_filter = 1'b0;
        rd_empty = 1'b1;
        #1;
        chk("freeze_pipe", pipe_en, 0);
        step();
        chk("freeze_hold", state, 5);
        rd_empty = 1'b0;
        f_co = 1'b1;
        #1;
        chk("fco_pipe", pipe_en, 0);
        step();
        chk("write_req", state, 6);
        chk("done_pulse", {done, rst_f_counter}, 2'b11);
        f_co = 1'b0;
        step();
        chk("wait_write", state, 7);
        chk("done_gone", done, 0);
        step();
        wr_stat = 2'b10;
        #1;
        chk("rst_result", rst_result, 1);
        step();
        chk("back_run", state, 5);
        chk("rst_result_gone", rst_result, 0);
        wr_stat = 2'b00;
        f_co = 1'b1;
        step();
        f_co = 1'b0;
        step();
        chk("tmo_ww1", state, 7);
        for (int i = 0; i < 3; i++) step();
        chk("tmo_ww4", state, 7);
        chk("tmo_not_yet", timeout_err, 0);
        step();
        chk("tmo_error", state, 11);
        chk("tmo_flag", {timeout_err, stall_signal}, 2'b11);
        start = 1'b1;
        step();
        chk("err_idle", state, 0);
        chk("tmo_clear", timeout_err, 0);
        start = 1'b0;
        step();
        sp_valid = 1'b1;
        go_to_run();
        f_co = 1'b1;
        step();
        f_co = 1'b0;
        step();
        wr_stat = 2'b11;
        step();
        chk("stall_state", state, 10);
        chk("stall_out", {stall_signal, pipe_en}, 4'b1000);
        wr_stat = 2'b01;
        step();
        chk("stall_hold", state, 10);
        wr_stat = 2'b10;
        #1;
        chk("stall_rst_result", rst_result, 1);
        step();
        chk("stall_resume", state, 5);
        wr_stat = 2'b00;
        is_last_filter = 1'b1;
        go_next_filter = 1'b1;
        #1;
        chk("last_no_nf", {next_filter, pipe_en}, 0);
        step();
        chk("next_if", state, 8);
        chk("rst_if_ctx", {rst_if_ctx, rst_stride}, 2'b11);
        is_last_filter = 1'b0;
        go_next_filter = 1'b0;
        step();
        chk("update_sp", state, 9);
        chk("next_start", next_start, 1);
        step();
        chk("refill_state", state, 4);
        chk("refill_pipe0", pipe_en, 3'b001);
        step();
        chk("refill_pipe1", pipe_en, 3'b011);
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_out", {chip_en, busy, pipe_en, next_start, done}, 0);
        #1 reset_n = 1'b1;
        ext_error = 1'b1;
        step();
        chk("idle_ignores_err", state, 0);
        ext_error = 1'b0;
        start = 1'b1;
        step();
        ext_error = 1'b1;
        step();
        chk("ext_err_state", state, 11);
        chk("ext_err_flag", {timeout_err, stall_signal}, 2'b01);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
